// File: rtl/alu_mc_if.sv
// Request/response bundle between a pipeline stage and the multi-cycle ALU.
// Carries no logic or state; it only adds what its master and slave drive.
// Both sides use valid/ready; the slave holds result until out_ready.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [3:0]       alu_ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  // requester side
  modport master (
    output in_valid, src_a, src_b, alu_ctrl, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  // ALU side
  modport slave (
    input  in_valid, src_a, src_b, alu_ctrl, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: logic/arith/shift ops plus optional shift-add multiply (ALU_MUL_EN).
// Latency: single-cycle ops 1 cycle; MULLO/MULHU WIDTH+1 cycles (only with ALU_MUL_EN).
// Backpressure: one op in flight; result held in DONE until out_ready, in_ready only in IDLE.
module alu_mc #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     rst_n,
  alu_mc_if.slave bus
);

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;
  logic             slt;

  assign shamt = bus.src_b[SHW-1:0];
  assign slt   = $signed(bus.src_a) < $signed(bus.src_b);

  // Single-cycle result, computed straight from the request so it loads on accept
  always_comb begin
    alu_res = '0;
    case (bus.alu_ctrl)
      4'b0000: alu_res = bus.src_a & bus.src_b;
      4'b0001: alu_res = bus.src_a | bus.src_b;
      4'b0010: alu_res = bus.src_a + bus.src_b;
      4'b0110: alu_res = bus.src_a - bus.src_b;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, slt};
      4'b0011: alu_res = bus.src_a << shamt;
      4'b0100: alu_res = bus.src_a >> shamt;
      4'b0101: alu_res = $unsigned($signed(bus.src_a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic                 busy_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplr_q;
  logic [SHW-1:0]       cnt_q;
  logic                 mulhi_q;
  logic                 is_mul;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]     mul_res;

  assign is_mul = (bus.alu_ctrl == 4'b1000) || (bus.alu_ctrl == 4'b1001);

  // One shift-add step: add into the upper half, carry falls into the shifted accumulator
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
    acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    mul_res = mulhi_q ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
  end

  assign bus.busy = busy_q;
`else
  assign bus.busy = 1'b0;
`endif

  // Control FSM with registered handshake outputs and result/zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
`ifdef ALU_MUL_EN
      busy_q      <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      cnt_q       <= '0;
      mulhi_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
`ifdef ALU_MUL_EN
            if (is_mul) begin
              state_q <= BUSY;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              acc_q   <= '0;
              mcand_q <= bus.src_a;
              mplr_q  <= bus.src_b;
              mulhi_q <= bus.alu_ctrl[0];
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
            end
`else
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= alu_res;
            zero_q      <= (alu_res == '0);
`endif
          end else begin
            // first cycle out of reset opens the input
            in_ready_q <= 1'b1;
          end
        end
`ifdef ALU_MUL_EN
        BUSY: begin
          acc_q  <= acc_nxt;
          mplr_q <= mplr_q >> 1;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == SHW'(WIDTH - 1)) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            result_q    <= mul_res;
            zero_q      <= (mul_res == '0);
          end
        end
`endif
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WIDTH=32: directed vector table, corner sequences, random ops vs model.
// Follows the multiply latency of whichever build ALU_MUL_EN selects.
// Drives and samples 1 time unit after each rising edge.
module tb_alu_mc;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   busy_seen = 0;

`ifdef ALU_MUL_EN
  localparam bit MUL = 1'b1;
`else
  localparam bit MUL = 1'b0;
`endif
  localparam int MUL_LAT  = MUL ? 33 : 1;
  localparam int MUL_BUSY = MUL ? 32 : 0;

  alu_mc_if #(.WIDTH(32)) bus ();

  alu_mc #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n === 1'b1 && bus.busy === 1'b1) busy_seen++;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          bsy;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Spec-level reference: arithmetic on plain integers
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned amt;
    longint      sa;
    logic [63:0] prod;
    amt  = b % 32;
    sa   = longint'($signed(a));
    prod = {32'b0, a} * {32'b0, b};
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return a << amt;
      4'b0100: return a >> amt;
      4'b0101: return 32'(sa >>> amt);
      4'b1000: return MUL ? prod[31:0] : 32'd0;
      4'b1001: return MUL ? prod[63:32] : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op);
    return (MUL && (op == 4'b1000 || op == 4'b1001)) ? 33 : 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request once in_ready is seen; returns just after the accept edge
  task automatic do_accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (bus.in_ready !== 1'b1) timeout("accept");
    bus.in_valid = 1'b1;
    bus.alu_ctrl = op;
    bus.src_a    = a;
    bus.src_b    = b;
    step();
    bus.in_valid = 1'b0;
    bus.src_a    = $urandom;
    bus.src_b    = $urandom;
    bus.alu_ctrl = 4'($urandom);
  endtask

  // Wait for out_valid, count latency and busy cycles, then complete the handshake
  task automatic collect(output logic [31:0] res, output logic z, output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      if (bus.busy === 1'b1) bcnt++;
      step();
      lat++;
    end
    if (bus.out_valid !== 1'b1) timeout("out_valid");
    res = bus.result;
    z   = bus.zero;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic        z;
    int          lat;
    int          bcnt;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    vecs[0]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0};
    vecs[1]  = '{4'b0111, 32'h80000000, 32'h00000001, 32'h00000001, 1, 0};
    vecs[2]  = '{4'b0101, 32'h80000000, 32'h00000024, 32'hF8000000, 1, 0};
    vecs[3]  = '{4'b0100, 32'h80000000, 32'h00000024, 32'h08000000, 1, 0};
    vecs[4]  = '{4'b0011, 32'h0000000F, 32'h00000021, 32'h0000001E, 1, 0};
    vecs[5]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1, 0};
    vecs[6]  = '{4'b0001, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1, 0};
    vecs[7]  = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1, 0};
    vecs[8]  = '{4'b0110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1, 0};
    vecs[9]  = '{4'b0111, 32'h00000001, 32'h80000000, 32'h00000000, 1, 0};
    vecs[10] = '{4'b1111, 32'h00000012, 32'h00000034, 32'h00000000, 1, 0};
    vecs[11] = '{4'b1000, 32'h00000007, 32'h00000006, MUL ? 32'd42 : 32'd0, MUL_LAT, MUL_BUSY};
    vecs[12] = '{4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL ? 32'hFFFFFFFE : 32'd0, MUL_LAT, MUL_BUSY};
    vecs[13] = '{4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL ? 32'h00000001 : 32'd0, MUL_LAT, MUL_BUSY};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.alu_ctrl  = '0;

    // Reset values
    repeat (3) step();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_zero", bus.zero, 1);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      do_accept(vecs[i].op, vecs[i].a, vecs[i].b);
      collect(res, z, lat, bcnt);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_zero", i), z, (vecs[i].exp == 32'd0));
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].bsy);
    end

    // Back-pressure: SUB 5-5 held for 10 cycles while a new request is waved at it
    do_accept(4'b0110, 32'd5, 32'd5);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = 4'b0010;
    bus.src_a    = 32'd1;
    bus.src_b    = 32'd1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp%0d_hold", i),
          {bus.out_valid, bus.in_ready, bus.zero, bus.result},
          {1'b1, 1'b0, 1'b1, 32'd0});
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_in_ready_after", bus.in_ready, 1);
    chk("bp_out_valid_after", bus.out_valid, 0);

    // Reset mid-operation (mid-multiply when the multiplier exists)
    if (MUL) begin
      do_accept(4'b1000, 32'd7, 32'd6);
      repeat (9) step();
      chk("mid_mul_busy", bus.busy, 1);
    end else begin
      do_accept(4'b0010, 32'd1, 32'd1);
      chk("pre_rst_result", bus.result, 2);
    end
    rst_n = 1'b0;
    step();
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_result", bus.result, 0);
    chk("midrst_zero", bus.zero, 1);
    chk("midrst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    step();
    chk("midrst_release_in_ready", bus.in_ready, 1);
    do_accept(4'b0010, 32'd2, 32'd3);
    collect(res, z, lat, bcnt);
    chk("after_rst_add", res, 5);
    chk("after_rst_add_latency", lat, 1);

    // Random ops against the reference model
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      b  = $urandom;
      a  = ($urandom_range(0, 3) == 0) ? b : $urandom;
      do_accept(op, a, b);
      collect(res, z, lat, bcnt);
      chk($sformatf("rnd%0d_op%0h_result", i, op), res, model(op, a, b));
      chk($sformatf("rnd%0d_op%0h_zero", i, op), z, (model(op, a, b) == 32'd0));
      chk($sformatf("rnd%0d_op%0h_latency", i, op), lat, model_lat(op));
    end

    if (MUL) chk("busy_ever_high", (busy_seen > 0), 1);
    else     chk("busy_never_high", busy_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
